jtag_lock_ctrl: RTL

JTAG_LOCK_CTRL -- requirements
Module: jtag_lock_ctrl

---
 rtl/jtag_lock_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/jtag_lock_ctrl.sv
// Debug-access lock controller: gates JTAG behind a key compare with a retry penalty.
// Optional permanent lockout after MAX_ATTEMPTS failures: define JTAG_LOCK_CTRL_LOCKOUT_EN.
//
// state    | meaning
// LOCKED   | JTAG gated, waiting for a key
// CHECK    | compare the captured key
// UNLOCKED | JTAG open until lock_req
// PENALTY  | wait PENALTY_CYCLES after a wrong key
// LOCKOUT  | permanently locked until reset
module jtag_lock_ctrl #(
    parameter int                KEY_W          = 32,
    parameter logic [KEY_W-1:0]  UNLOCK_KEY     = 32'hA5A5_5A5A,
    parameter int                MAX_ATTEMPTS   = 3,
    parameter int                PENALTY_CYCLES = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             lock_req,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_in,
    output logic             key_ready,
    output logic             lock_jtag_status,
    output logic             unlock_ok,
    output logic             unlock_fail,
    output logic             lockout,
    output logic [3:0]       fail_cnt
);

    typedef enum logic [2:0] {
        LOCKED   = 3'd0,
        CHECK    = 3'd1,
        UNLOCKED = 3'd2,
        PENALTY  = 3'd3,
        LOCKOUT  = 3'd4
    } state_t;

    localparam logic [7:0] PEN_LOAD = 8'(PENALTY_CYCLES - 1);
`ifdef JTAG_LOCK_CTRL_LOCKOUT_EN
    localparam logic [3:0] MAX_A = 4'(MAX_ATTEMPTS);
`endif

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [3:0]       fail_cnt_q, fail_cnt_d;
    logic [7:0]       pen_q, pen_d;
    logic             ok_q, ok_d;
    logic             fail_q, fail_d;
    logic             lock_q, lock_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= LOCKED;
            key_q      <= '0;
            fail_cnt_q <= '0;
            pen_q      <= '0;
            ok_q       <= 1'b0;
            fail_q     <= 1'b0;
            lock_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            fail_cnt_q <= fail_cnt_d;
            pen_q      <= pen_d;
            ok_q       <= ok_d;
            fail_q     <= fail_d;
            lock_q     <= lock_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        fail_cnt_d = fail_cnt_q;
        pen_d      = pen_q;
        ok_d       = 1'b0;
        fail_d     = 1'b0;
        case (state_q)
            LOCKED: begin
                if (key_valid) begin
                    key_d   = key_in;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (lock_req) begin
                    key_d   = '0;
                    state_d = LOCKED;
                end else if (key_q == UNLOCK_KEY) begin
                    ok_d       = 1'b1;
                    fail_cnt_d = '0;
                    state_d    = UNLOCKED;
                end else begin
                    fail_d = 1'b1;
                    if (fail_cnt_q != 4'hF) fail_cnt_d = fail_cnt_q + 4'd1;
`ifdef JTAG_LOCK_CTRL_LOCKOUT_EN
                    if (fail_cnt_d >= MAX_A) begin
                        state_d = LOCKOUT;
                    end else begin
                        state_d = PENALTY;
                        pen_d   = PEN_LOAD;
                    end
`else
                    state_d = PENALTY;
                    pen_d   = PEN_LOAD;
`endif
                end
            end
            UNLOCKED: begin
                if (lock_req) state_d = LOCKED;
            end
            PENALTY: begin
                if (pen_q == 8'd0) state_d = LOCKED;
                else               pen_d   = pen_q - 8'd1;
            end
            LOCKOUT: state_d = LOCKOUT;
            default: state_d = LOCKED;
        endcase
        // Gate opens only once UNLOCKED has been held across an edge; re-lock is immediate.
        lock_d = !((state_q == UNLOCKED) && (state_d == UNLOCKED));
    end

    assign key_ready        = (state_q == LOCKED);
    assign lock_jtag_status = lock_q;
    assign unlock_ok        = ok_q;
    assign unlock_fail      = fail_q;
    assign fail_cnt         = fail_cnt_q;
`ifdef JTAG_LOCK_CTRL_LOCKOUT_EN
    assign lockout          = (state_q == LOCKOUT);
`else
    assign lockout          = 1'b0;
`endif

endmodule
